// File: rtl/sobol_rng_pkg.sv
// Shared definitions for the 8-bit Sobol RNG: default word widths and the
// constant clog2 helper used to derive index widths.
package sobol_rng_pkg;

    localparam int unsigned LSZ_INWIDTH = 8;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'd1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    localparam int unsigned LSZ_LOGINWIDTH = clog2(LSZ_INWIDTH);

endpackage

// File: rtl/lsz_prio_enc.sv
// Combinational least-significant-zero encoder: index of the lowest '0' bit
// plus a flag for words with no zero bit (index then reads 0).
module lsz_prio_enc
    import sobol_rng_pkg::*;
#(
    parameter int unsigned INWIDTH    = LSZ_INWIDTH,
    parameter int unsigned LOGINWIDTH = clog2(INWIDTH)
) (
    input  logic [INWIDTH-1:0]    i_word,
    output logic [LOGINWIDTH-1:0] o_idx,
    output logic                  o_all_ones
);

    // Scan from the MSB down so the last hit wins, giving priority to bit 0.
    always_comb begin
        o_idx = '0;
        for (int unsigned i = INWIDTH; i > 0; i--) begin
            if (!i_word[i-1]) begin
                o_idx = LOGINWIDTH'(i - 1);
            end
        end
        o_all_ones = &i_word;
    end

endmodule

// File: rtl/lsz_detector.sv
// Registered least-significant-zero detector feeding the Sobol direction-vector
// select; one clock of latency, outputs hold while in_valid is low.
module lsz_detector
    import sobol_rng_pkg::*;
#(
    parameter int unsigned INWIDTH    = LSZ_INWIDTH,
    parameter int unsigned LOGINWIDTH = clog2(INWIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INWIDTH-1:0]    in,
    input  logic                  in_valid,
    output logic [LOGINWIDTH-1:0] out,
    output logic                  all_ones,
    output logic                  out_valid
);

    logic [LOGINWIDTH-1:0] w_idx;
    logic                  w_all_ones;
    logic [LOGINWIDTH-1:0] r_out;
    logic                  r_all_ones;
    logic                  r_out_valid;

    lsz_prio_enc #(
        .INWIDTH    (INWIDTH),
        .LOGINWIDTH (LOGINWIDTH)
    ) u_prio_enc (
        .i_word     (in),
        .o_idx      (w_idx),
        .o_all_ones (w_all_ones)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= '0;
            r_all_ones  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_out      <= w_idx;
                r_all_ones <= w_all_ones;
            end
        end
    end

    assign out       = r_out;
    assign all_ones  = r_all_ones;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_lsz_detector.sv
// Directed self-checking bench for lsz_detector (8-bit default and a 16-bit
// instance sharing clock and reset).
module tb_lsz_detector;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in8;
    logic        in_valid8;
    logic [2:0]  out8;
    logic        all_ones8;
    logic        out_valid8;
    logic [15:0] in16;
    logic        in_valid16;
    logic [3:0]  out16;
    logic        all_ones16;
    logic        out_valid16;

    int checks;
    int errors;

    lsz_detector dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in8),
        .in_valid  (in_valid8),
        .out       (out8),
        .all_ones  (all_ones8),
        .out_valid (out_valid8)
    );

    lsz_detector #(
        .INWIDTH    (16),
        .LOGINWIDTH (4)
    ) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in16),
        .in_valid  (in_valid16),
        .out       (out16),
        .all_ones  (all_ones16),
        .out_valid (out_valid16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Trailing-ones count of an 8-bit word, 0 when every bit is set.
    function automatic int unsigned tones8(input logic [7:0] v);
        int unsigned n;
        n = 0;
        while (n < 8 && v[n]) n++;
        return (n == 8) ? 0 : n;
    endfunction

    task automatic step8(input logic [7:0] v, input logic vld);
        in8       = v;
        in_valid8 = vld;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] cnt;
        checks     = 0;
        errors     = 0;
        rst_n      = 1'b0;
        in8        = 8'h05;
        in_valid8  = 1'b1;
        in16       = '0;
        in_valid16 = 1'b0;

        // Held in reset with valid input
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check("rst_out", 32'(out8), 32'd0);
            check("rst_all_ones", 32'(all_ones8), 32'd0);
            check("rst_out_valid", 32'(out_valid8), 32'd0);
        end
        rst_n = 1'b1;

        step8(8'h05, 1'b1);
        check("first_out", 32'(out8), 32'd1);
        check("first_valid", 32'(out_valid8), 32'd1);

        // Asynchronous reset mid-stream
        step8(8'h07, 1'b1);
        check("pre_rst_out", 32'(out8), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", 32'(out8), 32'd0);
        check("async_rst_valid", 32'(out_valid8), 32'd0);
        check("async_rst_all_ones", 32'(all_ones8), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Counter sweep, wrapping through 255 -> 0
        cnt = 8'h00;
        for (int k = 0; k < 500; k++) begin
            step8(cnt, 1'b1);
            check($sformatf("sweep_out_%02h", cnt), 32'(out8), 32'(tones8(cnt)));
            check($sformatf("sweep_all_ones_%02h", cnt), 32'(all_ones8), (cnt == 8'hFF) ? 32'd1 : 32'd0);
            check($sformatf("sweep_valid_%02h", cnt), 32'(out_valid8), 32'd1);
            cnt = cnt + 8'd1;
        end

        // All-ones then zero
        step8(8'hFF, 1'b1);
        check("ff_out", 32'(out8), 32'd0);
        check("ff_all_ones", 32'(all_ones8), 32'd1);
        step8(8'h00, 1'b1);
        check("00_out", 32'(out8), 32'd0);
        check("00_all_ones", 32'(all_ones8), 32'd0);

        // Non-counter patterns
        step8(8'b1011_0111, 1'b1);
        check("b7_out", 32'(out8), 32'd3);
        step8(8'b1111_1110, 1'b1);
        check("fe_out", 32'(out8), 32'd0);
        check("fe_all_ones", 32'(all_ones8), 32'd0);
        step8(8'b0111_1111, 1'b1);
        check("7f_out", 32'(out8), 32'd7);

        // Hold while in_valid low
        step8(8'h03, 1'b1);
        check("hold_pre_out", 32'(out8), 32'd2);
        check("hold_pre_valid", 32'(out_valid8), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step8(8'h00, 1'b0);
            check("hold_out", 32'(out8), 32'd2);
            check("hold_valid", 32'(out_valid8), 32'd0);
            check("hold_all_ones", 32'(all_ones8), 32'd0);
        end
        // Held all_ones flag
        step8(8'hFF, 1'b1);
        step8(8'h00, 1'b0);
        check("hold_ff_all_ones", 32'(all_ones8), 32'd1);

        // 16-bit instance
        in16       = 16'h7FFF;
        in_valid16 = 1'b1;
        @(posedge clk);
        #1;
        check("w16_7fff_out", 32'(out16), 32'd15);
        check("w16_7fff_all_ones", 32'(all_ones16), 32'd0);
        check("w16_7fff_valid", 32'(out_valid16), 32'd1);
        in16 = 16'hFFFF;
        @(posedge clk);
        #1;
        check("w16_ffff_out", 32'(out16), 32'd0);
        check("w16_ffff_all_ones", 32'(all_ones16), 32'd1);
        in16 = 16'h00FF;
        @(posedge clk);
        #1;
        check("w16_00ff_out", 32'(out16), 32'd8);
        check("w16_00ff_all_ones", 32'(all_ones16), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
